// File: rtl/memory_access_controller.sv
// memory_access_controller
// Initiator-side sequencer for a single-port synchronous memory with
// cs / write_en / read_en controls. Takes one command at a time from a
// valid/ready request channel, walks the memory pins through the write or
// two-phase read sequence, and returns read data on a valid/ready response
// channel. All memory-side outputs are registers, so nothing on req_* can
// reach mem_* combinationally, and reset clears them asynchronously.

module memory_access_controller #(
    parameter int data_size = 8,
    parameter int addr_size = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // request channel
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [addr_size-1:0] req_addr,
    input  logic [data_size-1:0] req_wdata,
    // response channel
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [data_size-1:0] rsp_rdata,
    // memory pins
    output logic                 mem_cs,
    output logic                 mem_write_en,
    output logic                 mem_read_en,
    output logic [addr_size-1:0] mem_address,
    output logic [data_size-1:0] mem_data_out,
    input  logic [data_size-1:0] mem_data_in
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WRITE    = 3'd1,
        S_RD_LOAD  = 3'd2,
        S_RD_DRIVE = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_req_ready;
    logic                 r_rsp_valid;
    logic [data_size-1:0] r_rsp_rdata;
    logic                 r_mem_cs;
    logic                 r_mem_write_en;
    logic                 r_mem_read_en;
    // Command registers double as the address/data pins, so the last
    // command's values stay on the bus while idle.
    logic [addr_size-1:0] r_mem_address;
    logic [data_size-1:0] r_mem_data_out;

    // Sequencer: every output is set on the edge that enters the state it
    // belongs to, so the pins always match the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_req_ready    <= 1'b1;
            r_rsp_valid    <= 1'b0;
            r_rsp_rdata    <= '0;
            r_mem_cs       <= 1'b0;
            r_mem_write_en <= 1'b0;
            r_mem_read_en  <= 1'b0;
            r_mem_address  <= '0;
            r_mem_data_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // req_ready is high in this state, so valid alone accepts
                    if (req_valid) begin
                        r_mem_address  <= req_addr;
                        r_mem_data_out <= req_wdata;
                        r_mem_cs       <= 1'b1;
                        r_mem_write_en <= req_write;
                        r_mem_read_en  <= 1'b0;
                        r_req_ready    <= 1'b0;
                        r_state        <= req_write ? S_WRITE : S_RD_LOAD;
                    end
                end
                S_WRITE: begin
                    // memory commits the write on this edge
                    r_mem_cs       <= 1'b0;
                    r_mem_write_en <= 1'b0;
                    r_req_ready    <= 1'b1;
                    r_state        <= S_IDLE;
                end
                S_RD_LOAD: begin
                    // memory loaded its read register on this edge; now enable output
                    r_mem_read_en <= 1'b1;
                    r_state       <= S_RD_DRIVE;
                end
                S_RD_DRIVE: begin
                    // the only place the data bus is ever sampled
                    r_rsp_rdata   <= mem_data_in;
                    r_rsp_valid   <= 1'b1;
                    r_mem_cs      <= 1'b0;
                    r_mem_read_en <= 1'b0;
                    r_state       <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    r_req_ready    <= 1'b1;
                    r_rsp_valid    <= 1'b0;
                    r_mem_cs       <= 1'b0;
                    r_mem_write_en <= 1'b0;
                    r_mem_read_en  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign mem_cs       = r_mem_cs;
    assign mem_write_en = r_mem_write_en;
    assign mem_read_en  = r_mem_read_en;
    assign mem_address  = r_mem_address;
    assign mem_data_out = r_mem_data_out;

endmodule

// File: tb/tb_memory_access_controller.sv
// Bench for memory_access_controller: a behavioural 16x8 memory on the pins,
// a plain array as the reference contents, a directed vector table, a
// back-to-back sweep, random traffic and reset-mid-operation sequences.

module tb_memory_access_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid, req_write, rsp_ready;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       req_ready, rsp_valid;
    logic [7:0] rsp_rdata;
    logic       mem_cs, mem_write_en, mem_read_en;
    logic [3:0] mem_address;
    logic [7:0] mem_data_out, mem_data_in;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_count = 0;

    logic [7:0] mem [16];
    logic [7:0] mem_rd_reg;
    logic [7:0] ref_mem [16];

    memory_access_controller #(.data_size(8), .addr_size(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_cs(mem_cs), .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
        .mem_address(mem_address), .mem_data_out(mem_data_out),
        .mem_data_in(mem_data_in)
    );

    always #5 clk = ~clk;

    // Memory device: write on cs&we, load read register on cs&!we.
    always @(posedge clk) begin
        if (mem_cs && mem_write_en) begin
            mem[mem_address] <= mem_data_out;
            wr_count <= wr_count + 1;
        end
        if (mem_cs && !mem_write_en) mem_rd_reg <= mem[mem_address];
    end
    // Garbage value stands in for high-Z so stray sampling is visible.
    assign mem_data_in = (mem_cs && mem_read_en) ? mem_rd_reg : 8'hEE;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, n_tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        int w0;
        w0 = wr_count;
        check("wr_ready_before", 32'(req_ready), 1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
        tick();                         // E0: accept
        req_valid = 1'b0;
        check("wr_cs",        32'(mem_cs), 1);
        check("wr_we",        32'(mem_write_en), 1);
        check("wr_re",        32'(mem_read_en), 0);
        check("wr_addr",      32'(mem_address), 32'(a));
        check("wr_data",      32'(mem_data_out), 32'(d));
        check("wr_ready_low", 32'(req_ready), 0);
        check("wr_no_rsp",    32'(rsp_valid), 0);
        tick();                         // E1: memory written
        check("wr_cs_off",    32'(mem_cs), 0);
        check("wr_we_off",    32'(mem_write_en), 0);
        check("wr_ready_back",32'(req_ready), 1);
        check("wr_no_rsp2",   32'(rsp_valid), 0);
        check("wr_addr_hold", 32'(mem_address), 32'(a));
        check("wr_one_strobe",32'(wr_count - w0), 1);
        ref_mem[a] = d;
    endtask

    task automatic do_read(input logic [3:0] a, input logic [7:0] exp, input int delay);
        int w0;
        w0 = wr_count;
        check("rd_ready_before", 32'(req_ready), 1);
        rsp_ready = (delay == 0);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = 8'($urandom);
        tick();                         // E0: accept, RD_LOAD
        req_valid = 1'b0;
        check("rdload_cs",   32'(mem_cs), 1);
        check("rdload_we",   32'(mem_write_en), 0);
        check("rdload_re",   32'(mem_read_en), 0);
        check("rdload_addr", 32'(mem_address), 32'(a));
        tick();                         // E1: RD_DRIVE
        check("rddrv_cs",    32'(mem_cs), 1);
        check("rddrv_re",    32'(mem_read_en), 1);
        check("rddrv_we",    32'(mem_write_en), 0);
        check("rddrv_norsp", 32'(rsp_valid), 0);
        tick();                         // E2: response valid
        check("rsp_valid",   32'(rsp_valid), 1);
        check("rsp_rdata",   32'(rsp_rdata), 32'(exp));
        check("rsp_cs_off",  32'(mem_cs), 0);
        check("rsp_re_off",  32'(mem_read_en), 0);
        check("rsp_ready_lo",32'(req_ready), 0);
        for (int i = 0; i < delay; i++) begin
            // stray write request must be ignored while the response waits
            req_valid = 1'b1; req_write = 1'b1; req_addr = 4'($urandom); req_wdata = 8'($urandom);
            tick();
            check("bp_valid",  32'(rsp_valid), 1);
            check("bp_rdata",  32'(rsp_rdata), 32'(exp));
            check("bp_ready",  32'(req_ready), 0);
            check("bp_cs",     32'(mem_cs), 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();                         // handshake edge
        check("hs_valid_clr", 32'(rsp_valid), 0);
        check("hs_ready",     32'(req_ready), 1);
        check("rd_no_write",  32'(wr_count - w0), 0);
    endtask

    typedef struct {
        bit         wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        int         delay;
    } vec_t;

    initial begin
        vec_t vecs[7];
        int   w0;
        logic [7:0] old;

        vecs[0] = '{1'b1, 4'd3,  8'hA5, 8'h00, 0};
        vecs[1] = '{1'b0, 4'd3,  8'h00, 8'hA5, 0};
        vecs[2] = '{1'b0, 4'd3,  8'h00, 8'hA5, 5};  // backpressure
        vecs[3] = '{1'b1, 4'd15, 8'hFF, 8'h00, 0};
        vecs[4] = '{1'b1, 4'd0,  8'h01, 8'h00, 0};
        vecs[5] = '{1'b0, 4'd15, 8'h00, 8'hFF, 1};
        vecs[6] = '{1'b0, 4'd0,  8'h00, 8'h01, 2};

        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'($urandom); req_write = 1'($urandom);
            req_addr = 4'($urandom); req_wdata = 8'($urandom); rsp_ready = 1'($urandom);
            tick();
            check("rst_req_ready", 32'(req_ready), 1);
            check("rst_rsp_valid", 32'(rsp_valid), 0);
            check("rst_rsp_rdata", 32'(rsp_rdata), 0);
            check("rst_cs",        32'(mem_cs), 0);
            check("rst_we",        32'(mem_write_en), 0);
            check("rst_re",        32'(mem_read_en), 0);
            check("rst_addr",      32'(mem_address), 0);
            check("rst_dout",      32'(mem_data_out), 0);
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        rst_n = 1'b1;
        tick();

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].wdata);
            else            do_read(vecs[i].addr, vecs[i].exp_rdata, vecs[i].delay);
        end

        // Back-to-back sweep with req_valid held through non-ready cycles
        w0 = wr_count;
        for (int a = 0; a < 16; a++) begin
            req_valid = 1'b1; req_write = 1'b1;
            req_addr = 4'(a); req_wdata = 8'(a) ^ 8'h5A;
            tick();                     // accepted
            check("sweep_we",   32'(mem_write_en), 1);
            check("sweep_addr", 32'(mem_address), 32'(a));
            tick();                     // held valid, ignored while in WRITE
            check("sweep_ready",32'(req_ready), 1);
            ref_mem[a] = 8'(a) ^ 8'h5A;
        end
        req_valid = 1'b0;
        check("sweep_writes", 32'(wr_count - w0), 16);
        tick();
        do_read(4'd15, 8'h55, 0);
        do_read(4'd0,  8'h5A, 0);
        do_read(4'd7,  8'h5D, 0);

        // Random traffic against the reference array
        for (int n = 0; n < 40; n++) begin
            logic [3:0] a;
            a = 4'($urandom_range(15));
            if ($urandom_range(1) == 1) do_write(a, 8'($urandom));
            else                        do_read(a, ref_mem[a], int'($urandom_range(3)));
        end

        // Reset during WRITE: the write must not land
        old = ref_mem[9];
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd9; req_wdata = ~old;
        tick();
        req_valid = 1'b0;
        check("rw_in_write", 32'(mem_write_en), 1);
        w0 = wr_count;
        #2 rst_n = 1'b0;
        #1;
        check("rw_cs_async", 32'(mem_cs), 0);
        check("rw_we_async", 32'(mem_write_en), 0);
        tick();
        tick();
        check("rw_no_write", 32'(wr_count - w0), 0);
        check("rw_no_rsp",   32'(rsp_valid), 0);
        rst_n = 1'b1;
        tick();
        do_read(4'd9, old, 0);

        // Reset during RD_DRIVE: read discarded, no response
        req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd4;
        tick();
        req_valid = 1'b0;
        tick();
        check("rr_in_drive", 32'(mem_read_en), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rr_cs_async", 32'(mem_cs), 0);
        check("rr_re_async", 32'(mem_read_en), 0);
        tick();
        check("rr_no_rsp",   32'(rsp_valid), 0);
        tick();
        check("rr_no_rsp2",  32'(rsp_valid), 0);
        rst_n = 1'b1;
        tick();
        check("rr_idle",     32'(req_ready), 1);
        do_read(4'd4, ref_mem[4], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
